// File: rtl/gb_video_pkg.sv
// Shared Game Boy video types, source geometry and the power-on palette.
package gb_video_pkg;
  localparam int SRC_W    = 160;
  localparam int SRC_H    = 144;
  localparam int FB_DEPTH = SRC_W * SRC_H;

  typedef logic [1:0]  shade_t;
  typedef logic [23:0] rgb_t;
  typedef logic [14:0] fb_addr_t;

  localparam rgb_t PAL_DEFAULT [4] = '{24'hE0F8D0, 24'h88C070, 24'h346856, 24'h081820};

  // Halve each 8-bit channel independently.
  function automatic rgb_t dim_rgb(rgb_t c);
    return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
  endfunction
endpackage

// File: rtl/gb_framebuffer_ram.sv
// 23040x2 simple dual-port framebuffer, registered read, read-first on collision.
module gb_framebuffer_ram
  import gb_video_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_we,
  input  logic [14:0] i_waddr,
  input  logic [1:0]  i_wdata,
  input  logic [14:0] i_raddr,
  output logic [1:0]  o_rdata
);
  shade_t r_mem [FB_DEPTH];
  shade_t r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/gb_frame_scaler.sv
// Captures the 160x144 PPU stream and replays it 3x scaled into the 640x480 raster.
// Optional build macro GB_SCALER_SCANLINE_EN dims the last output row of each scaled source row.
module gb_frame_scaler
  import gb_video_pkg::*;
#(
  parameter int   SCALE      = 3,
  parameter int   ORIGIN_X   = 80,
  parameter int   ORIGIN_Y   = 24,
  parameter rgb_t BORDER_RGB = 24'h000000
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic [9:0]  cx,
  input  logic [9:0]  cy,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [1:0]  pix_data,
  input  logic        pal_we,
  input  logic [1:0]  pal_idx,
  input  logic [23:0] pal_rgb,
  output logic [23:0] rgb,
  output logic        overflow
);
  localparam logic [9:0] X_LO     = 10'(ORIGIN_X);
  localparam logic [9:0] X_HI     = 10'(ORIGIN_X + SRC_W * SCALE);
  localparam logic [9:0] Y_LO     = 10'(ORIGIN_Y);
  localparam logic [9:0] Y_HI     = 10'(ORIGIN_Y + SRC_H * SCALE);
  localparam logic [1:0] SUB_LAST = 2'(SCALE - 1);
  localparam fb_addr_t   WR_END   = fb_addr_t'(FB_DEPTH);
  localparam fb_addr_t   ROW_STEP = fb_addr_t'(SRC_W);

  fb_addr_t r_wr_addr;
  logic     r_overflow;
  logic     w_wr_full;
  logic     w_we;
  fb_addr_t w_waddr;

  assign w_wr_full = (r_wr_addr == WR_END);
  assign w_we      = pix_valid & (frame_start | ~w_wr_full);
  assign w_waddr   = frame_start ? '0 : r_wr_addr;

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_wr_addr  <= '0;
      r_overflow <= 1'b0;
    end else if (frame_start) begin
      r_wr_addr  <= pix_valid ? fb_addr_t'(1) : '0;
      r_overflow <= 1'b0;
    end else if (pix_valid) begin
      if (w_wr_full) r_overflow <= 1'b1;
      else           r_wr_addr  <= r_wr_addr + 1'b1;
    end
  end

  // Stage 0: scan counters; row_base steps by SRC_W so no multiply is needed.
  logic       w_x_win, w_y_win;
  logic [7:0] r_sx;
  logic [1:0] r_subx, r_suby;
  fb_addr_t   r_row_base;
  logic       r_in_win0;

  assign w_x_win = (cx >= X_LO) && (cx < X_HI);
  assign w_y_win = (cy >= Y_LO) && (cy < Y_HI);

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_sx       <= '0;
      r_subx     <= '0;
      r_suby     <= '0;
      r_row_base <= '0;
      r_in_win0  <= 1'b0;
    end else begin
      r_in_win0 <= w_x_win & w_y_win;
      if (cx == X_LO) begin
        r_sx   <= '0;
        r_subx <= '0;
      end else if (w_x_win) begin
        if (r_subx == SUB_LAST) begin
          r_subx <= '0;
          r_sx   <= r_sx + 1'b1;
        end else begin
          r_subx <= r_subx + 1'b1;
        end
      end
      if (cx == '0) begin
        if (cy == Y_LO) begin
          r_suby     <= '0;
          r_row_base <= '0;
        end else if (w_y_win) begin
          if (r_suby == SUB_LAST) begin
            r_suby     <= '0;
            r_row_base <= r_row_base + ROW_STEP;
          end else begin
            r_suby <= r_suby + 1'b1;
          end
        end
      end
    end
  end

  // Stage 1: framebuffer read.
  fb_addr_t w_rd_addr;
  shade_t   w_shade;
  logic     r_in_win1;
`ifdef GB_SCALER_SCANLINE_EN
  logic [1:0] r_suby1;
`endif

  assign w_rd_addr = r_row_base + fb_addr_t'(r_sx);

  gb_framebuffer_ram u_fb (
    .i_clk   (clk_pixel),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (pix_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_shade)
  );

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_in_win1 <= 1'b0;
`ifdef GB_SCALER_SCANLINE_EN
      r_suby1   <= '0;
`endif
    end else begin
      r_in_win1 <= r_in_win0;
`ifdef GB_SCALER_SCANLINE_EN
      r_suby1   <= r_suby;
`endif
    end
  end

  // Stage 2: palette lookup; a same-edge palette write is seen one lookup later.
  rgb_t r_pal [4];
  rgb_t r_rgb;
  rgb_t w_pix;

  always_comb begin
    w_pix = r_pal[w_shade];
`ifdef GB_SCALER_SCANLINE_EN
    if (r_suby1 == SUB_LAST) w_pix = dim_rgb(w_pix);
`endif
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_rgb <= BORDER_RGB;
      for (int i = 0; i < 4; i++) r_pal[i] <= PAL_DEFAULT[i];
    end else begin
      if (pal_we) r_pal[pal_idx] <= pal_rgb;
      r_rgb <= r_in_win1 ? w_pix : BORDER_RGB;
    end
  end

  assign rgb      = r_rgb;
  assign overflow = r_overflow;
endmodule
